// File: rtl/core_pkg.sv
// Shared types and constants for the core memory-stage data-bus master.
// The funct3 helpers treat loads and stores alike, since only the size bits matter here.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } dbus_state_t;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        MISALIGN = 2'b01,
        BUSERR   = 2'b10,
        TIMEOUT  = 2'b11
    } dbus_fault_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size lives in funct3[1:0]; the unsigned variants share the same alignment rule.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_load_align.sv
// Combinational load-data alignment: shifts the addressed lane down and
// sign- or zero-extends according to funct3.
module core_load_align
    import core_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_bus_dat,
    output logic [31:0] o_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = i_bus_dat >> {i_lane, 3'b000};
        case (i_funct3)
            F3_B:    o_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    o_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   o_data = {24'h000000, shifted[7:0]};
            F3_HU:   o_data = {16'h0000, shifted[15:0]};
            default: o_data = shifted;
        endcase
    end

endmodule

// File: rtl/core_dbus_ctrl.sv
// Memory-stage data-bus master: one Wishbone-style classic cycle per load/store,
// stalling the pipeline while the cycle runs and reporting result/fault in DONE.
module core_dbus_ctrl
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_sel,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_vld,
    output logic [1:0]  o_fault,
    output logic        o_bus_cyc,
    output logic        o_bus_stb,
    output logic        o_bus_we,
    output logic [31:0] o_bus_adr,
    output logic [31:0] o_bus_dat,
    output logic [3:0]  o_bus_sel,
    input  logic        i_bus_ack,
    input  logic        i_bus_err,
    input  logic [31:0] i_bus_dat,
    output dbus_state_t o_dbg_state
);

    localparam int unsigned CNT_RAW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W    = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dbus_state_t      state_q, state_d;
    dbus_fault_t      fault_q, fault_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [3:0]       sel_q, sel_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       lane_q, lane_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        misaligned;
    logic        flush_eff;
    logic [31:0] load_ext;
    logic        stall;
    logic        rdata_vld;
    dbus_fault_t fault_out;

    core_load_align u_load_align (
        .i_funct3  (funct3_q),
        .i_lane    (lane_q),
        .i_bus_dat (i_bus_dat),
        .o_data    (load_ext)
    );

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        funct3_d   = funct3_q;
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        rdata_d    = rdata_q;
        stall      = 1'b0;
        rdata_vld  = 1'b0;
        fault_out  = NONE;
        misaligned = is_misaligned(i_funct3, i_addr[1:0]);
        flush_eff  = flush_q | i_flush;

        case (state_q)
            IDLE: begin
                if (i_req) begin
                    stall    = 1'b1;
                    flush_d  = i_flush;
                    we_d     = i_we;
                    funct3_d = i_funct3;
                    lane_d   = i_addr[1:0];
                    if (misaligned) begin
                        fault_d = MISALIGN;
                        state_d = DONE;
                    end else begin
                        fault_d = NONE;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        adr_d   = {i_addr[31:2], 2'b00};
                        dat_d   = i_wdata;
                        sel_d   = i_sel;
                        cnt_d   = '0;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                stall = 1'b1;
                if (i_flush) flush_d = 1'b1;
                // Error wins over a simultaneous ack.
                if (i_bus_err) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    fault_d = BUSERR;
                    state_d = DONE;
                end else if (i_bus_ack) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    fault_d = NONE;
                    if (!we_q) rdata_d = load_ext;
                    state_d = DONE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    fault_d = TIMEOUT;
                    state_d = DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                flush_d   = 1'b0;
                rdata_vld = !we_q && (fault_q == NONE) && !flush_eff;
                fault_out = flush_eff ? NONE : fault_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            fault_q  <= NONE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            funct3_q <= '0;
            lane_q   <= '0;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            fault_q  <= fault_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_stall     = stall;
    assign o_rdata     = rdata_q;
    assign o_rdata_vld = rdata_vld;
    assign o_fault     = fault_out;
    assign o_bus_cyc   = cyc_q;
    assign o_bus_stb   = stb_q;
    assign o_bus_we    = we_q;
    assign o_bus_adr   = adr_q;
    assign o_bus_dat   = dat_q;
    assign o_bus_sel   = sel_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_core_dbus_ctrl.sv
// Bench for core_dbus_ctrl: directed and random load/store transactions with a
// bus responder, checked through an expected-result queue.
module tb_core_dbus_ctrl;
    import core_pkg::*;

    localparam int TO     = 4;
    localparam int R_ACK  = 0;
    localparam int R_ERR  = 1;
    localparam int R_BOTH = 2;
    localparam int R_NONE = 3;

    logic        clk;
    logic        i_reset, i_req, i_we, i_flush;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic [3:0]  i_sel;
    logic        o_stall, o_rdata_vld;
    logic [31:0] o_rdata;
    logic [1:0]  o_fault;
    logic        o_bus_cyc, o_bus_stb, o_bus_we;
    logic [31:0] o_bus_adr, o_bus_dat;
    logic [3:0]  o_bus_sel;
    logic        i_bus_ack, i_bus_err;
    logic [31:0] i_bus_dat;
    dbus_state_t o_dbg_state;

    int          checks;
    int          failures;
    int          cyc_cnt;
    int          done_at;
    int          stb_at;
    logic [31:0] last_rdata;
    logic [34:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    core_dbus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_sel       (i_sel),
        .i_flush     (i_flush),
        .o_stall     (o_stall),
        .o_rdata     (o_rdata),
        .o_rdata_vld (o_rdata_vld),
        .o_fault     (o_fault),
        .o_bus_cyc   (o_bus_cyc),
        .o_bus_stb   (o_bus_stb),
        .o_bus_we    (o_bus_we),
        .o_bus_adr   (o_bus_adr),
        .o_bus_dat   (o_bus_dat),
        .o_bus_sel   (o_bus_sel),
        .i_bus_ack   (i_bus_ack),
        .i_bus_err   (i_bus_err),
        .i_bus_dat   (i_bus_dat),
        .o_dbg_state (o_dbg_state)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[int'(lane)*8 +: 8];
        h = lane[1] ? d[31:16] : d[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return d;
        endcase
    endfunction

    // Drives one request and plays the bus slave; leaves i_req high so a
    // following access can be issued back-to-back in the IDLE cycle.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel, input logic [31:0] rdat,
                          input int resp, input int ack_at, input int flush_at);
        logic        mis;
        logic [1:0]  fraw;
        logic [1:0]  efault;
        logic        evld;
        int          exp_stb;
        int          stall_n;
        int          stb_n;
        bit          done;
        logic [34:0] exp;
        mis = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        if (mis) begin
            fraw = 2'b01; exp_stb = 0;
        end else if (resp == R_ACK) begin
            fraw = 2'b00; exp_stb = ack_at;
        end else if (resp == R_NONE) begin
            fraw = 2'b11; exp_stb = TO;
        end else begin
            fraw = 2'b10; exp_stb = ack_at;
        end
        efault = (flush_at > 0) ? 2'b00 : fraw;
        evld   = !we && (fraw == 2'b00) && (flush_at == 0);
        if (!we && !mis && resp == R_ACK) last_rdata = model_load(f3, addr[1:0], rdat);
        exp_q.push_back({evld, efault, last_rdata});

        @(posedge clk); #1;
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr;
        i_wdata = wdata; i_sel = sel; i_bus_dat = rdat;
        stall_n = 0; stb_n = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (o_bus_stb) begin
                stb_n++;
                if (stb_n == 1) begin
                    stb_at = cyc_cnt;
                    check_eq("bus_adr", o_bus_adr, {addr[31:2], 2'b00});
                    check_eq("bus_we", o_bus_we, we);
                    if (we) begin
                        check_eq("bus_dat", o_bus_dat, wdata);
                        check_eq("bus_sel", o_bus_sel, sel);
                    end
                end
                if (stb_n == ack_at && resp != R_NONE) begin
                    i_bus_ack = (resp == R_ACK || resp == R_BOTH);
                    i_bus_err = (resp == R_ERR || resp == R_BOTH);
                end
                if (stb_n == flush_at) i_flush = 1'b1;
            end
            if (o_stall) begin
                stall_n++;
            end else begin
                done    = 1;
                done_at = cyc_cnt;
                exp     = exp_q.pop_front();
                check_eq("result", {o_rdata_vld, o_fault, o_rdata}, exp);
                check_eq("done_cyc", o_bus_cyc, 1'b0);
            end
            if (!done) begin
                @(posedge clk); #1;
                i_bus_ack = 1'b0; i_bus_err = 1'b0; i_flush = 1'b0;
            end
        end
        if (!done) begin
            check_eq("done_seen", 1'b0, 1'b1);
            void'(exp_q.pop_front());
        end
        check_eq("stall_cycles", stall_n, exp_stb + 1);
        check_eq("stb_cycles", stb_n, exp_stb);
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        check_eq("idle_fault", o_fault, 2'b00);
        check_eq("idle_vld", o_rdata_vld, 1'b0);
        check_eq("idle_cyc", o_bus_cyc, 1'b0);
    endtask

    initial begin
        int gap;
        logic [2:0]  rf3;
        logic [31:0] raddr;
        checks = 0; failures = 0; last_rdata = '0;
        i_reset = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0;
        i_wdata = '0; i_sel = '0; i_flush = 1'b0;
        i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_dat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state", o_dbg_state, IDLE);
        check_eq("rst_bus", {o_bus_cyc, o_bus_stb, o_bus_we, o_bus_adr, o_bus_dat, o_bus_sel}, '0);
        check_eq("rst_out", {o_rdata, o_rdata_vld, o_fault, o_stall}, '0);
        i_reset = 1'b0;

        access(1'b1, F3_W, 32'h1000, 32'hDEADBEEF, 4'b1111, 32'h0, R_ACK, 2, 0);
        idle_check();
        access(1'b0, F3_B,  32'h1001, 32'h0, 4'b0010, 32'h123480FF, R_ACK, 1, 0);
        access(1'b0, F3_BU, 32'h1001, 32'h0, 4'b0010, 32'h123480FF, R_ACK, 2, 0);
        access(1'b0, F3_HU, 32'h1002, 32'h0, 4'b1100, 32'h123480FF, R_ACK, 1, 0);
        access(1'b0, F3_H,  32'h1000, 32'h0, 4'b0011, 32'h55AA8001, R_ACK, 3, 0);
        access(1'b0, F3_W,  32'h1004, 32'h0, 4'b1111, 32'hCAFEF00D, R_ACK, 1, 0);
        access(1'b0, F3_W,  32'h1002, 32'h0, 4'b1111, 32'h0, R_ACK, 1, 0);
        idle_check();
        access(1'b0, F3_HU, 32'h1003, 32'h0, 4'b1000, 32'h0, R_ACK, 1, 0);
        idle_check();
        access(1'b0, F3_W, 32'h3000, 32'h0, 4'b1111, 32'h0, R_NONE, 0, 0);
        idle_check();
        access(1'b0, F3_W, 32'h3004, 32'h0, 4'b1111, 32'h11111111, R_BOTH, 2, 0);
        access(1'b1, F3_H, 32'h3006, 32'h7777BEEF, 4'b1100, 32'h0, R_ERR, 1, 0);
        idle_check();

        // reset in the middle of a bus cycle
        @(posedge clk); #1;
        i_req = 1'b1; i_we = 1'b0; i_funct3 = F3_W; i_addr = 32'h2000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_bus_stb) break;
        end
        check_eq("rst_mid_stb_seen", o_bus_stb, 1'b1);
        i_reset = 1'b1; i_req = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid", {o_bus_cyc, o_bus_stb, o_stall}, 3'b000);
        access(1'b0, F3_W, 32'h2000, 32'h0, 4'b1111, 32'h0BADF00D, R_ACK, 1, 0);

        // flush during bus cycle: completes but result suppressed
        access(1'b0, F3_W, 32'h2008, 32'h0, 4'b1111, 32'hA5A5A5A5, R_ACK, 3, 1);
        access(1'b0, F3_W, 32'h200C, 32'h0, 4'b1111, 32'h0, R_ERR, 2, 1);
        idle_check();

        // back-to-back loads, ack in the first strobe cycle
        access(1'b0, F3_W, 32'h0, 32'h0, 4'b1111, 32'h01020304, R_ACK, 1, 0);
        gap = done_at;
        access(1'b0, F3_W, 32'h4, 32'h0, 4'b1111, 32'h05060708, R_ACK, 1, 0);
        check_eq("b2b_gap", stb_at - gap, 2);
        idle_check();

        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 4))
                0: rf3 = F3_B;
                1: rf3 = F3_BU;
                2: rf3 = F3_H;
                3: rf3 = F3_HU;
                default: rf3 = F3_W;
            endcase
            raddr = {$urandom_range(0, 16'hFFFF), 2'b00} | 32'($urandom_range(0, 3));
            access(1'b0, rf3, raddr, 32'h0, 4'b1111, $urandom, R_ACK, $urandom_range(1, 3), 0);
        end
        idle_check();

        check_eq("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
